// File: rtl/mips_pkg.sv
// mips_pkg: ALU select codes, opcode/funct encodings, operand-B selects and control FSM states
package mips_pkg;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_MUL  = 3'd5;
  localparam logic [2:0] ALU_DIV  = 3'd6;
  localparam logic [2:0] ALU_PASS = 3'd7;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_MUL   = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BR   = 2'd3;
  typedef enum logic [2:0] {RST_ST, FETCH, DECODE, EXEC, MEM, WB, BRANCH, TRAP} state_t;
endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: instruction fields, datapath status and control strobes between controller and datapath
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       z_flag;
  logic       mem_ready;
  logic [2:0] alu_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       pc_write;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       pc_src;
  logic       retire;
  logic       illegal;
  modport master (
    input  opcode, funct, z_flag, mem_ready,
    output alu_sel, alu_src_a, alu_src_b, mem_read, mem_write, ir_write, reg_write,
           pc_write, iord, reg_dst, mem_to_reg, pc_src, retire, illegal
  );
  modport slave (
    output opcode, funct, z_flag, mem_ready,
    input  alu_sel, alu_src_a, alu_src_b, mem_read, mem_write, ir_write, reg_write,
           pc_write, iord, reg_dst, mem_to_reg, pc_src, retire, illegal
  );
endinterface

// File: rtl/mips_alu_dec.sv
// mips_alu_dec: opcode/funct to ALU select, flagging encodings outside the supported set
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_sel,
  output logic       is_legal
);
  // R-type selects by funct, I-type by opcode; unlisted encodings fall back to PASS
  always_comb begin
    alu_sel = ALU_PASS;
    is_legal = 1'b1;
    if (opcode == OP_RTYPE)
      case (funct)
        FN_ADD:  alu_sel = ALU_ADD;
        FN_SUB:  alu_sel = ALU_SUB;
        FN_AND:  alu_sel = ALU_AND;
        FN_OR:   alu_sel = ALU_OR;
        FN_SLT:  alu_sel = ALU_SLT;
        FN_MUL:  alu_sel = ALU_MUL;
        FN_DIV:  alu_sel = ALU_DIV;
        FN_NOP:  alu_sel = ALU_PASS;
        default: is_legal = 1'b0;
      endcase
    else
      case (opcode)
        OP_ADDI, OP_LW, OP_SW: alu_sel = ALU_ADD;
        OP_ANDI: alu_sel = ALU_AND;
        OP_ORI:  alu_sel = ALU_OR;
        OP_SLTI: alu_sel = ALU_SLT;
        OP_BEQ:  alu_sel = ALU_SUB;
        default: is_legal = 1'b0;
      endcase
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM; CTRL_ILLEGAL_TRAP_EN sends unlisted encodings to a sticky TRAP state
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  mips_multicycle_ctrl_if.master bus
);
  localparam int CW = $clog2(MULDIV_CYCLES) + 1;
  state_t st;
  logic [CW-1:0] cnt;
  logic [2:0] dec_sel;
  logic legal, is_r, is_lw, is_sw, is_beq, md_done, trap;
  mips_alu_dec u_dec (.opcode(bus.opcode), .funct(bus.funct), .alu_sel(dec_sel), .is_legal(legal));
  assign is_r = bus.opcode == OP_RTYPE;
  assign is_lw = bus.opcode == OP_LW;
  assign is_sw = bus.opcode == OP_SW;
  assign is_beq = bus.opcode == OP_BEQ;
  assign md_done = !(dec_sel == ALU_MUL || dec_sel == ALU_DIV) || cnt == CW'(MULDIV_CYCLES - 1);
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign trap = !legal;
`else
  assign trap = 1'b0;
`endif
  // state sequencing; the counter only runs while a MUL/DIV is being held in EXEC
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= RST_ST;
      cnt <= '0;
    end else begin
      cnt <= st == EXEC && !md_done ? cnt + 1'b1 : '0;
      case (st)
        RST_ST:     st <= FETCH;
        FETCH:      st <= bus.mem_ready ? DECODE : FETCH;
        DECODE:     st <= is_beq ? BRANCH : trap ? TRAP : EXEC;
        EXEC:       st <= !md_done ? EXEC : is_lw || is_sw ? MEM : WB;
        MEM:        st <= !bus.mem_ready ? MEM : is_sw ? FETCH : WB;
        WB, BRANCH: st <= FETCH;
        default:    st <= TRAP;
      endcase
    end
  // Moore decode of the state, with mem_ready gating the completing strobes and z_flag gating the branch
  always_comb begin
    bus.alu_sel = st == EXEC ? dec_sel : st == BRANCH ? ALU_SUB : ALU_ADD;
    bus.alu_src_a = st == EXEC || st == BRANCH;
    bus.alu_src_b = st == FETCH ? SRCB_FOUR : st == DECODE ? SRCB_BR : st == EXEC && !is_r ? SRCB_IMM : SRCB_RT;
    bus.mem_read = st == FETCH || (st == MEM && is_lw);
    bus.mem_write = st == MEM && is_sw;
    bus.ir_write = st == FETCH && bus.mem_ready;
    bus.pc_write = (st == FETCH && bus.mem_ready) || (st == BRANCH && bus.z_flag);
    bus.reg_write = st == WB && legal && !(is_r && bus.funct == FN_NOP);
    bus.iord = st == MEM;
    bus.reg_dst = st == WB && is_r;
    bus.mem_to_reg = st == WB && is_lw;
    bus.pc_src = st == BRANCH;
    bus.retire = st == WB || st == BRANCH || (st == MEM && is_sw && bus.mem_ready);
    bus.illegal = st == TRAP;
  end
endmodule
